// File: rtl/status_register.sv
// Processor status register (P): latches N V D I Z C, builds the push byte, gates IRQ and NMI.
// Latency: flag writes visible 1 cycle later; push_data combinational; irq/nmi after sync stages + 1.
// Backpressure: none; every write strobe is accepted in the cycle it is presented.
module status_register #(
  parameter bit RESET_I         = 1'b1,
  parameter int NMI_SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_negative,
  input  logic       alu_overflow,
  input  logic       alu_zero,
  input  logic       alu_carry,
  input  logic       alu_we,
  input  logic [3:0] alu_mask,
  input  logic       bit_we,
  input  logic [7:0] operand,
  input  logic       sc_we,
  input  logic [2:0] sc_sel,
  input  logic       sc_val,
  input  logic       pull_we,
  input  logic [7:0] pull_data,
  input  logic       push_brk,
  input  logic       irq_entry,
  input  logic       instr_boundary,
  input  logic       irq_n,
  input  logic       nmi_n,
  input  logic       nmi_ack,
  output logic       p_n,
  output logic       p_v,
  output logic       p_d,
  output logic       p_i,
  output logic       p_z,
  output logic       p_c,
  output logic [7:0] push_data,
  output logic       irq_mask_eff,
  output logic       irq_request,
  output logic       nmi_pending
);

  // A request for zero stages still gets one flop so the lines are never sampled raw.
  localparam int SS = (NMI_SYNC_STAGES < 1) ? 1 : NMI_SYNC_STAGES;

  logic          n_nxt, v_nxt, d_nxt, i_nxt, z_nxt, c_nxt;
  logic [SS-1:0] irq_sr;
  logic [SS-1:0] nmi_sr;
  logic          irq_sync;
  logic          nmi_sync;
  logic          nmi_prev;
  logic          nmi_edge;
  logic          unused_bits;

  // B and bit 5 are not stored; BIT only needs the top two operand bits.
  assign unused_bits = ^{pull_data[5:4], operand[5:0]};

  assign irq_sync = irq_sr[SS-1];
  assign nmi_sync = nmi_sr[SS-1];
  assign nmi_edge = nmi_prev & ~nmi_sync;

  assign push_data = {p_n, p_v, 1'b1, push_brk, p_d, p_i, p_z, p_c};

  // Next flag values: lowest-priority writer first so higher ones overwrite it.
  always_comb begin
    n_nxt = p_n;
    v_nxt = p_v;
    d_nxt = p_d;
    i_nxt = p_i;
    z_nxt = p_z;
    c_nxt = p_c;
    if (alu_we) begin
      if (alu_mask[3]) n_nxt = alu_negative;
      if (alu_mask[2]) v_nxt = alu_overflow;
      if (alu_mask[1]) z_nxt = alu_zero;
      if (alu_mask[0]) c_nxt = alu_carry;
    end
    if (bit_we) begin
      n_nxt = operand[7];
      v_nxt = operand[6];
      z_nxt = alu_zero;
    end
    if (sc_we) begin
      case (sc_sel)
        3'd0:    c_nxt = sc_val;
        3'd1:    i_nxt = sc_val;
        3'd2:    d_nxt = sc_val;
        3'd3:    v_nxt = sc_val;
        default: ;
      endcase
    end
    if (pull_we) begin
      n_nxt = pull_data[7];
      v_nxt = pull_data[6];
      d_nxt = pull_data[3];
      i_nxt = pull_data[2];
      z_nxt = pull_data[1];
      c_nxt = pull_data[0];
    end
    // Interrupt entry always masks, even against a pull or CLI in the same cycle.
    if (irq_entry) i_nxt = 1'b1;
  end

  // Flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_n <= 1'b0;
      p_v <= 1'b0;
      p_d <= 1'b0;
      p_i <= RESET_I;
      p_z <= 1'b0;
      p_c <= 1'b0;
    end else begin
      p_n <= n_nxt;
      p_v <= v_nxt;
      p_d <= d_nxt;
      p_i <= i_nxt;
      p_z <= z_nxt;
      p_c <= c_nxt;
    end
  end

  // Synchronizers for the external interrupt lines (idle high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_sr <= '1;
      nmi_sr <= '1;
    end else begin
      irq_sr[0] <= irq_n;
      nmi_sr[0] <= nmi_n;
      for (int k = 1; k < SS; k++) begin
        irq_sr[k] <= irq_sr[k-1];
        nmi_sr[k] <= nmi_sr[k-1];
      end
    end
  end

  // Delayed I mask and level IRQ request; the mask samples I as it was before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_mask_eff <= RESET_I;
      irq_request  <= 1'b0;
    end else begin
      if (instr_boundary) irq_mask_eff <= p_i;
      irq_request <= ~irq_sync & ~irq_mask_eff;
    end
  end

  // NMI falling-edge capture; a new edge wins over a coincident acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_prev    <= 1'b1;
      nmi_pending <= 1'b0;
    end else begin
      nmi_prev <= nmi_sync;
      if (nmi_edge)     nmi_pending <= 1'b1;
      else if (nmi_ack) nmi_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_status_register.sv
module tb_status_register;

  localparam int SYNC = 2;

  typedef struct {
    logic [7:0] p;
    logic       mask;
    logic       req;
    logic       pend;
    logic [7:0] push;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alu_negative = 0, alu_overflow = 0, alu_zero = 0, alu_carry = 0;
  logic       alu_we = 0;
  logic [3:0] alu_mask = 0;
  logic       bit_we = 0;
  logic [7:0] operand = 0;
  logic       sc_we = 0;
  logic [2:0] sc_sel = 0;
  logic       sc_val = 0;
  logic       pull_we = 0;
  logic [7:0] pull_data = 0;
  logic       push_brk = 0;
  logic       irq_entry = 0;
  logic       instr_boundary = 0;
  logic       irq_n = 1;
  logic       nmi_n = 1;
  logic       nmi_ack = 0;
  logic       p_n, p_v, p_d, p_i, p_z, p_c;
  logic [7:0] push_data;
  logic       irq_mask_eff, irq_request, nmi_pending;

  int checks = 0;
  int passed = 0;

  exp_t sbq[$];
  exp_t mon_e;

  // Reference state: P as a byte in stack layout, line histories newest first.
  logic [7:0] m_p;
  logic       m_mask, m_req, m_pend, m_nmi_prev;
  logic       irq_h[$];
  logic       nmi_h[$];
  int         amap[4] = '{0, 1, 6, 7};

  always #5 clk = ~clk;

  status_register #(.RESET_I(1'b1), .NMI_SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_negative(alu_negative), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_we(alu_we), .alu_mask(alu_mask),
    .bit_we(bit_we), .operand(operand),
    .sc_we(sc_we), .sc_sel(sc_sel), .sc_val(sc_val),
    .pull_we(pull_we), .pull_data(pull_data),
    .push_brk(push_brk), .irq_entry(irq_entry),
    .instr_boundary(instr_boundary),
    .irq_n(irq_n), .nmi_n(nmi_n), .nmi_ack(nmi_ack),
    .p_n(p_n), .p_v(p_v), .p_d(p_d), .p_i(p_i), .p_z(p_z), .p_c(p_c),
    .push_data(push_data),
    .irq_mask_eff(irq_mask_eff), .irq_request(irq_request),
    .nmi_pending(nmi_pending)
  );

  function automatic logic [7:0] dut_p();
    return {p_n, p_v, 2'b00, p_d, p_i, p_z, p_c};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_p = 8'h04;
    m_mask = 1'b1;
    m_req = 1'b0;
    m_pend = 1'b0;
    m_nmi_prev = 1'b1;
    irq_h.delete();
    nmi_h.delete();
    for (int k = 0; k < SYNC; k++) begin
      irq_h.push_back(1'b1);
      nmi_h.push_back(1'b1);
    end
  endtask

  // Advance the model by one clock using the current inputs, queue the result, run the clock.
  task automatic step();
    logic [7:0] np;
    logic [3:0] av;
    logic       isync, nsync;
    exp_t       e;
    np = m_p;
    av = {alu_negative, alu_overflow, alu_zero, alu_carry};
    if (alu_we)
      for (int j = 0; j < 4; j++)
        if (alu_mask[j]) np[amap[j]] = av[j];
    if (bit_we) begin
      np[7] = operand[7];
      np[6] = operand[6];
      np[1] = alu_zero;
    end
    if (sc_we) begin
      if (sc_sel == 3'd0) np[0] = sc_val;
      if (sc_sel == 3'd1) np[2] = sc_val;
      if (sc_sel == 3'd2) np[3] = sc_val;
      if (sc_sel == 3'd3) np[6] = sc_val;
    end
    if (pull_we) np = pull_data & 8'hCF;
    if (irq_entry) np[2] = 1'b1;
    isync = irq_h[SYNC-1];
    nsync = nmi_h[SYNC-1];
    m_req = ~isync & ~m_mask;
    if (instr_boundary) m_mask = m_p[2];
    m_pend = (m_nmi_prev & ~nsync) | (m_pend & ~nmi_ack);
    m_nmi_prev = nsync;
    irq_h.push_front(irq_n);
    void'(irq_h.pop_back());
    nmi_h.push_front(nmi_n);
    void'(nmi_h.pop_back());
    m_p = np;
    e.p = np;
    e.mask = m_mask;
    e.req = m_req;
    e.pend = m_pend;
    e.push = np | 8'h20 | (push_brk ? 8'h10 : 8'h00);
    sbq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    alu_we = 0; bit_we = 0; sc_we = 0; pull_we = 0;
    irq_entry = 0; instr_boundary = 0; nmi_ack = 0;
  endtask

  // Monitor: outputs settle every cycle; compare them against the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("flags",        dut_p(),             mon_e.p);
      chk("push_data",    push_data,           mon_e.push);
      chk("irq_mask_eff", {7'd0, irq_mask_eff}, {7'd0, mon_e.mask});
      chk("irq_request",  {7'd0, irq_request},  {7'd0, mon_e.req});
      chk("nmi_pending",  {7'd0, nmi_pending},  {7'd0, mon_e.pend});
    end
  end

  task automatic rand_cycles(input int n);
    for (int t = 0; t < n; t++) begin
      alu_we = ($urandom_range(0, 2) == 0);
      alu_mask = 4'($urandom);
      {alu_negative, alu_overflow, alu_zero, alu_carry} = 4'($urandom);
      bit_we = ($urandom_range(0, 5) == 0);
      operand = 8'($urandom);
      sc_we = ($urandom_range(0, 3) == 0);
      sc_sel = 3'($urandom);
      sc_val = 1'($urandom);
      pull_we = ($urandom_range(0, 6) == 0);
      pull_data = 8'($urandom);
      push_brk = 1'($urandom);
      irq_entry = ($urandom_range(0, 9) == 0);
      instr_boundary = ($urandom_range(0, 2) == 0);
      nmi_ack = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) irq_n = ~irq_n;
      if ($urandom_range(0, 5) == 0) nmi_n = ~nmi_n;
      step();
    end
    idle();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_flags", dut_p(), 8'h04);
    chk("reset_mask", {7'd0, irq_mask_eff}, 8'h01);
    rst_n = 1;

    // ALU mask 1010 with all ALU flags high.
    alu_we = 1; alu_mask = 4'b1010;
    {alu_negative, alu_overflow, alu_zero, alu_carry} = 4'b1111;
    step();
    chk("alu_mask_nvzc", {p_n, p_v, p_z, p_c}, {4'b0000, 4'b1010});
    idle();

    // Pull beats set/clear beats ALU.
    pull_we = 1; pull_data = 8'hC3;
    sc_we = 1; sc_sel = 3'd0; sc_val = 0;
    alu_we = 1; alu_mask = 4'hF;
    {alu_negative, alu_overflow, alu_zero, alu_carry} = 4'b0000;
    push_brk = 0;
    step();
    chk("pull_prio_p", dut_p(), 8'hC3);
    chk("pull_prio_push", push_data, 8'hE3);
    idle();

    // BIT with operand 0x40, C stays 1.
    bit_we = 1; operand = 8'h40; alu_zero = 1;
    step();
    chk("bit_nvzc", {p_n, p_v, p_z, p_c}, {4'b0000, 4'b0111});
    idle();

    // CLI latency with IRQ held low.
    sc_we = 1; sc_sel = 3'd1; sc_val = 1; irq_n = 0;
    step();
    idle();
    repeat (3) step();
    sc_we = 1; sc_sel = 3'd1; sc_val = 0; instr_boundary = 1;
    step();
    idle();
    chk("cli_mask_b1", {7'd0, irq_mask_eff}, 8'h01);
    repeat (2) step();
    chk("cli_req_held", {7'd0, irq_request}, 8'h00);
    instr_boundary = 1;
    step();
    idle();
    chk("cli_mask_b2", {7'd0, irq_mask_eff}, 8'h00);
    chk("cli_req_lag", {7'd0, irq_request}, 8'h00);
    step();
    chk("cli_req_rise", {7'd0, irq_request}, 8'h01);
    irq_n = 1;
    repeat (3) step();

    // NMI: first fall, then a second fall coinciding with an ack.
    nmi_n = 0;
    repeat (SYNC) step();
    chk("nmi_early", {7'd0, nmi_pending}, 8'h00);
    step();
    chk("nmi_set", {7'd0, nmi_pending}, 8'h01);
    nmi_n = 1;
    repeat (3) step();
    nmi_n = 0;
    repeat (SYNC) step();
    nmi_ack = 1;
    step();
    nmi_ack = 0;
    chk("nmi_edge_vs_ack", {7'd0, nmi_pending}, 8'h01);
    repeat (2) step();
    nmi_ack = 1;
    step();
    nmi_ack = 0;
    chk("nmi_ack_clear", {7'd0, nmi_pending}, 8'h00);
    repeat (4) step();
    chk("nmi_held_low", {7'd0, nmi_pending}, 8'h00);
    nmi_n = 1;

    // irq_entry overrides a pull that clears I.
    pull_we = 1; pull_data = 8'h00; irq_entry = 1;
    step();
    idle();
    chk("entry_over_pull", {7'd0, p_i}, 8'h01);

    rand_cycles(400);

    // Asynchronous reset in the middle of a clock period.
    #1;
    rst_n = 0;
    #1;
    push_brk = 1;
    #1;
    chk("async_reset_p", dut_p(), 8'h04);
    chk("async_reset_push", push_data, 8'h34);
    chk("async_reset_mask", {7'd0, irq_mask_eff}, 8'h01);
    chk("async_reset_req", {7'd0, irq_request}, 8'h00);
    chk("async_reset_nmi", {7'd0, nmi_pending}, 8'h00);
    sbq.delete();
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1;
    irq_n = 1; nmi_n = 1;
    repeat (2) step();
    rand_cycles(200);

    @(posedge clk);
    #2;
    chk("queue_drained", 8'(sbq.size()), 8'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/status_register.md
Name: status_register

Overview:
- Processor status register (P) for the 6502 core. It is the consumer end of the ALU flag outputs.
- Latches N/V/Z/C from the ALU under control-unit masks, and executes the flag set/clear instructions, BIT, PLP/RTI pulls and PHP/BRK/IRQ pushes.
- Owns interrupt gating: the delayed effective I mask, the IRQ request, and NMI falling-edge capture.
- Sits between the ALU, the control unit and the stack data path.

Parameters:
- RESET_I, 1, value of the I flag and of irq_mask_eff after reset.
- NMI_SYNC_STAGES, 2, number of synchronizer flops on nmi_n and irq_n (minimum 1).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- alu_negative, alu_overflow, alu_zero, alu_carry  input  1 each  ALU flag outputs.
- alu_we  input  1  apply alu_mask this cycle.
- alu_mask  input  4  per-flag enable, bit3 = N, bit2 = V, bit1 = Z, bit0 = C.
- bit_we  input  1  BIT update: N <= operand[7], V <= operand[6], Z <= alu_zero.
- operand  input  8  memory operand for BIT.
- sc_we  input  1  single-flag set/clear.
- sc_sel  input  3  selects the flag: 0 = C, 1 = I, 2 = D, 3 = V; other codes are ignored.
- sc_val  input  1  value written by set/clear.
- pull_we  input  1  load P from pull_data (PLP/RTI).
- pull_data  input  8  byte pulled from the stack.
- push_brk  input  1  B bit value placed in push_data.
- irq_entry  input  1  interrupt/BRK entry; sets I.
- instr_boundary  input  1  pulse at the opcode-fetch cycle.
- irq_n  input  1  level-sensitive IRQ line, active low.
- nmi_n  input  1  edge-sensitive NMI line, active low.
- nmi_ack  input  1  control unit has begun NMI entry.
- p_n, p_v, p_d, p_i, p_z, p_c  output  1 each  flag register contents.
- push_data  output  8  {N, V, 1, push_brk, D, I, Z, C}, combinational.
- irq_mask_eff  output  1  I value used for IRQ polling.
- irq_request  output  1  synchronized IRQ asserted and irq_mask_eff = 0 (registered).
- nmi_pending  output  1  latched NMI edge.

Behaviour:
- Reset (rst_n = 0, asynchronous) applies these values:
  - N, V, D, Z, C = 0.
  - I = RESET_I.
  - irq_mask_eff = RESET_I.
  - irq_request = 0, nmi_pending = 0.
  - Synchronizer flops and the NMI previous-sample flop = 1.
- Reset deasserted mid-instruction: the register holds its reset values until the first write.
- Flag write priority, highest first, resolved per flag in the same cycle:
  1. pull_we: all six flags from pull_data; bits 5 and 4 are ignored.
  2. sc_we.
  3. bit_we.
  4. alu_we: a flag is written only where its alu_mask bit is 1.
- irq_entry forces I = 1 after all of the above, so it overrides a pull or clear in the same cycle.
- A flag with no active writer holds its value.
- All flag writes take effect on the next rising edge, i.e. 1-cycle latency, visible on the p_* outputs.
- push_data reflects current register contents; a write in the same cycle is not visible until the next cycle.
- Delayed mask:
  - On an edge where instr_boundary = 1, irq_mask_eff <= the I value held before that edge.
  - A same-cycle I write therefore reaches irq_mask_eff only at the following boundary.
  - This models the one-instruction CLI/SEI/PLP latency.
  - Otherwise irq_mask_eff holds.
- IRQ:
  - irq_n passes through NMI_SYNC_STAGES flops.
  - irq_request <= ~irq_sync & ~irq_mask_eff, re-evaluated every cycle. It is not latched; deasserting irq_n drops it.
- NMI:
  - nmi_n is synchronized the same way; nmi_prev holds the previous synchronized sample.
  - A falling edge (nmi_prev = 1, sync = 0) sets nmi_pending.
  - nmi_ack clears nmi_pending.
  - If an edge and nmi_ack occur in the same cycle, nmi_pending stays 1.
  - A held-low nmi_n produces no further edges until it returns high.
  - nmi_pending ignores I.

Test Plan:
- Reset check: drive rst_n low asynchronously mid-clock -> p_* = 0 except p_i = 1; push_data with push_brk = 1 = 0x34; irq_mask_eff = 1; nmi_pending = 0.
- ALU mask: alu_we = 1, alu_mask = 0b1010, ALU flags N = 1 V = 1 Z = 1 C = 1, starting from all-zero flags -> next cycle N = 1, Z = 1, V = 0, C = 0.
- Pull versus set/clear versus ALU in the same cycle:
  - Stimulus: pull_we with pull_data = 0xC3, sc_we sel = 0 val = 0, alu_we mask = 0xF with all flags 0.
  - Required: P = {N1, V1, D0, I0, Z1, C1}; push_data with push_brk = 0 = 0xE3.
- CLI latency:
  - Stimulus: I = 1 with irq_n low. Apply sc_we sel = 1 val = 0 together with instr_boundary. Apply the next instr_boundary 3 cycles later.
  - Required: irq_mask_eff stays 1 after the first boundary and becomes 0 after the second. irq_request rises 1 cycle after irq_mask_eff falls.
- BIT with operand = 0x40 and alu_zero = 1 -> N = 0, V = 1, Z = 1, C unchanged.
- NMI:
  - Stimulus: drive nmi_n low. Pulse nmi_ack in the same cycle as a second falling edge.
  - Required: nmi_pending sets NMI_SYNC_STAGES + 1 cycles after the first fall and stays 1 through the coincident ack. With nmi_n held low and a lone ack, it clears and stays 0.
